// File: rtl/window_reader_if.sv
// Bus bundle for window_reader: frame control, producer pointer, buffer read port
// and the registered window output stream.
interface window_reader_if #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned READ_SIZE  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
);
    localparam int unsigned AW = $clog2(SIZE);

    logic                             start;
    logic [LEN_WIDTH-1:0]             frame_len;
    logic                             wr_commit;
    logic [AW-1:0]                    write_addr;
    logic                             buf_full;
    logic [AW-1:0]                    read_addr;
    logic [DATA_WIDTH*READ_SIZE-1:0]  buf_data;
    logic [DATA_WIDTH*READ_SIZE-1:0]  out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             done;
    logic                             err;

    modport master (
        input  start, frame_len, wr_commit, buf_data, out_ready,
        output write_addr, buf_full, read_addr, out_data, out_valid, done, err
    );

    modport slave (
        output start, frame_len, wr_commit, buf_data, out_ready,
        input  write_addr, buf_full, read_addr, out_data, out_valid, done, err
    );
endinterface

// File: rtl/window_reader.sv
// Read-side controller for the window buffer: owns write/read pointers and occupancy,
// streams READ_SIZE-word windows and retires STRIDE words each. Optional sticky err: WINDOW_READER_ERR_EN.
module window_reader #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned WRITE_SIZE = 2,
    parameter int unsigned READ_SIZE  = 2,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    window_reader_if.master   bus
);
    localparam int unsigned PTR_W = $clog2(SIZE);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned WIN_W = DATA_WIDTH * READ_SIZE;

    localparam logic [OCC_W-1:0] C_WRITE   = OCC_W'(WRITE_SIZE);
    localparam logic [OCC_W-1:0] C_READ    = OCC_W'(READ_SIZE);
    localparam logic [OCC_W-1:0] C_STRIDE  = OCC_W'(STRIDE);
    localparam logic [OCC_W-1:0] C_FULL_TH = OCC_W'(SIZE - WRITE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0]      r_rd_ptr, w_rd_ptr_nxt;
    logic [OCC_W-1:0]      r_occ, w_occ_nxt;
    logic [LEN_WIDTH-1:0]  r_remaining, w_rem_nxt;
    logic [WIN_W-1:0]      r_data_p1, w_data_nxt;
    logic                  r_vld_p1, w_vld_nxt;

    logic                  w_full;
    logic                  w_commit_ok;
    logic                  w_load;
    logic [OCC_W-1:0]      w_occ_add;
    logic [OCC_W-1:0]      w_occ_sub;

    // Availability and back-pressure both derive from registered occupancy only.
    assign w_full      = (r_occ > C_FULL_TH);
    assign w_commit_ok = ((r_state == S_RUN) || (r_state == S_FLUSH)) && bus.wr_commit && !w_full;
    assign w_load      = (r_state == S_RUN) && (r_occ >= C_READ) && (r_remaining != '0)
                         && (!r_vld_p1 || bus.out_ready);
    assign w_occ_add   = w_commit_ok ? C_WRITE : '0;
    assign w_occ_sub   = w_load ? C_STRIDE : '0;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_occ_nxt    = r_occ;
        w_rem_nxt    = r_remaining;
        w_data_nxt   = r_data_p1;
        w_vld_nxt    = r_vld_p1;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_wr_ptr_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_occ_nxt    = '0;
                    w_vld_nxt    = 1'b0;
                    w_rem_nxt    = bus.frame_len;
                    w_state_nxt  = (bus.frame_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_commit_ok) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(WRITE_SIZE);
                w_occ_nxt = r_occ + w_occ_add - w_occ_sub;
                if (w_load) begin
                    w_data_nxt   = bus.buf_data;
                    w_vld_nxt    = 1'b1;
                    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(STRIDE);
                    w_rem_nxt    = r_remaining - LEN_WIDTH'(1);
                    if (r_remaining == LEN_WIDTH'(1)) w_state_nxt = S_FLUSH;
                end else if (r_vld_p1 && bus.out_ready) begin
                    w_vld_nxt = 1'b0;
                end
            end
            S_FLUSH: begin
                // Late commits still move the producer pointer but feed no window.
                if (w_commit_ok) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(WRITE_SIZE);
                w_occ_nxt = r_occ + w_occ_add;
                if (!r_vld_p1 || bus.out_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_occ_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Stage p1: registered window and its valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_remaining <= '0;
            r_data_p1   <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_occ       <= w_occ_nxt;
            r_remaining <= w_rem_nxt;
            r_data_p1   <= w_data_nxt;
            r_vld_p1    <= w_vld_nxt;
        end
    end

`ifdef WINDOW_READER_ERR_EN
    logic r_err;
    logic w_err_set;
    logic w_err_clr;

    assign w_err_set = (bus.wr_commit && w_full) || (bus.start && (r_state != S_IDLE));
    assign w_err_clr = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_err <= 1'b0;
        else if (w_err_clr) r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.write_addr = r_wr_ptr;
    assign bus.read_addr  = r_rd_ptr;
    assign bus.buf_full   = w_full;
    assign bus.out_data   = r_data_p1;
    assign bus.out_valid  = r_vld_p1;
    assign bus.done       = (r_state == S_DONE);
endmodule

// File: tb/tb_window_reader.sv
// Directed bench for window_reader: frame flow, back-pressure, overflow, wrap,
// async reset mid-frame and zero-length frames, with a static buffer buf[i]=i.
module tb_window_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_reader_if #(.SIZE(8), .READ_SIZE(2), .DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

    window_reader #(
        .SIZE(8), .WRITE_SIZE(2), .READ_SIZE(2), .STRIDE(1), .DATA_WIDTH(8), .LEN_WIDTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [8];
    assign bus.buf_data = {mem[bus.read_addr + 3'd1], mem[bus.read_addr]};

`ifdef WINDOW_READER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.done) break;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int nwin;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.frame_len = '0;
        bus.wr_commit = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_wa", 32'(bus.write_addr), 32'd0);
        chk("rst_ra", 32'(bus.read_addr), 32'd0);
        chk("rst_full", 32'(bus.buf_full), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        #10 rst = 1'b1;
        step();

        // Basic frame: 3 windows, 4 commits, out_ready held high.
        bus.start = 1'b1; bus.frame_len = 8'd3; bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0; bus.wr_commit = 1'b1;
        step();
        chk("b_wa1", 32'(bus.write_addr), 32'd2);
        chk("b_novalid", 32'(bus.out_valid), 32'd0);
        step();
        chk("b_valid", 32'(bus.out_valid), 32'd1);
        chk("b_win0", 32'(bus.out_data), 32'h0100);
        chk("b_ra1", 32'(bus.read_addr), 32'd1);
        step();
        chk("b_win1", 32'(bus.out_data), 32'h0201);
        chk("b_ra2", 32'(bus.read_addr), 32'd2);
        step();
        chk("b_win2", 32'(bus.out_data), 32'h0302);
        chk("b_wa0", 32'(bus.write_addr), 32'd0);
        bus.wr_commit = 1'b0;
        step();
        chk("b_done", 32'(bus.done), 32'd1);
        chk("b_vld_off", 32'(bus.out_valid), 32'd0);
        step();
        chk("b_done_pulse", 32'(bus.done), 32'd0);
        chk("b_full_after", 32'(bus.buf_full), 32'd0);

        // Back-pressure, with an ignored start in the middle of the hold.
        bus.start = 1'b1; bus.frame_len = 8'd3; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0; bus.wr_commit = 1'b1;
        step();
        step();
        bus.wr_commit = 1'b0;
        chk("bp_win0", 32'(bus.out_data), 32'h0100);
        for (int h = 0; h < 5; h++) begin
            if (h == 2) begin bus.start = 1'b1; bus.frame_len = 8'd0; end
            step();
            bus.start = 1'b0;
            chk($sformatf("bp_hold_data%0d", h), 32'(bus.out_data), 32'h0100);
            chk($sformatf("bp_hold_ra%0d", h), 32'(bus.read_addr), 32'd1);
            chk($sformatf("bp_hold_vld%0d", h), 32'(bus.out_valid), 32'd1);
        end
        chk("bp_err", 32'(bus.err), 32'(ERR_EXP));
        bus.out_ready = 1'b1;
        step();
        chk("bp_win1", 32'(bus.out_data), 32'h0201);
        chk("bp_ra2", 32'(bus.read_addr), 32'd2);
        wait_done("bp_done", 20);
        step();

        // Overflow: stalled output while the producer keeps committing.
        bus.start = 1'b1; bus.frame_len = 8'd3; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0;
        chk("ov_err_clr", 32'(bus.err), 32'd0);
        bus.wr_commit = 1'b1;
        step();
        step();
        step();
        chk("ov_notfull5", 32'(bus.buf_full), 32'd0);
        step();
        chk("ov_full", 32'(bus.buf_full), 32'd1);
        chk("ov_wa0", 32'(bus.write_addr), 32'd0);
        chk("ov_ra1", 32'(bus.read_addr), 32'd1);
        step();
        chk("ov_wa_hold", 32'(bus.write_addr), 32'd0);
        chk("ov_full_hold", 32'(bus.buf_full), 32'd1);
        chk("ov_err", 32'(bus.err), 32'(ERR_EXP));
        bus.wr_commit = 1'b0; bus.out_ready = 1'b1;
        wait_done("ov_done", 20);
        step();

        // Wrap: 10 windows with the producer throttled by buf_full.
        bus.start = 1'b1; bus.frame_len = 8'd10; bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        chk("wr_err_clr", 32'(bus.err), 32'd0);
        k = 0;
        for (int c = 0; c < 80; c++) begin
            bus.wr_commit = !bus.buf_full;
            step();
            if (bus.out_valid && k < 10) begin
                chk($sformatf("wr_win%0d", k), 32'(bus.out_data),
                    32'({8'((k + 1) % 8), 8'(k % 8)}));
                chk($sformatf("wr_ra%0d", k), 32'(bus.read_addr), 32'((k + 1) % 8));
                k++;
            end
            if (bus.done) break;
        end
        bus.wr_commit = 1'b0;
        chk("wr_done", 32'(bus.done), 32'd1);
        chk("wr_count", 32'(k), 32'd10);
        chk("wr_err_none", 32'(bus.err), 32'd0);
        step();

        // Asynchronous reset while a window is pending.
        bus.start = 1'b1; bus.frame_len = 8'd3; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0; bus.wr_commit = 1'b1;
        step();
        step();
        bus.wr_commit = 1'b0;
        chk("rr_pre_vld", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rr_vld", 32'(bus.out_valid), 32'd0);
        chk("rr_data", 32'(bus.out_data), 32'd0);
        chk("rr_ra", 32'(bus.read_addr), 32'd0);
        chk("rr_wa", 32'(bus.write_addr), 32'd0);
        chk("rr_done", 32'(bus.done), 32'd0);
        chk("rr_full", 32'(bus.buf_full), 32'd0);
        #3 rst = 1'b1;
        bus.start = 1'b1; bus.frame_len = 8'd1; bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0; bus.wr_commit = 1'b1;
        step();
        bus.wr_commit = 1'b0;
        nwin = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.out_valid) begin
                nwin++;
                chk("rr_win", 32'(bus.out_data), 32'h0100);
            end
            if (bus.done) break;
        end
        chk("rr_done_seen", 32'(bus.done), 32'd1);
        chk("rr_nwin", 32'(nwin), 32'd1);
        step();

        // Zero-length frame.
        bus.start = 1'b1; bus.frame_len = 8'd0;
        step();
        bus.start = 1'b0;
        chk("z_done", 32'(bus.done), 32'd1);
        chk("z_vld", 32'(bus.out_valid), 32'd0);
        step();
        chk("z_done_off", 32'(bus.done), 32'd0);
        chk("z_vld_off", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
